// File: rtl/core_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | core_pkg: shared ALU command codes and decode control bundle      |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package core_pkg;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       mem_read;
    logic       mem_write;
    logic       wb_en;
    logic       b;
    logic       s;
    logic       valid;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t BUBBLE_CTRL = '{
    exe_cmd:   EXE_NOP,
    mem_read:  1'b0,
    mem_write: 1'b0,
    wb_en:     1'b0,
    b:         1'b0,
    s:         1'b0,
    valid:     1'b0
  };

  // An invalid decode slot must never carry side-effecting control bits.
  function automatic ctrl_bundle_t gate_ctrl(input ctrl_bundle_t c);
    return c.valid ? c : BUBBLE_CTRL;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sat_counter: event counter that sticks at its maximum value       |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             hold,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (inc && !hold && (count_q != C_MAX)) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | id_ex_stage_reg: decode->execute pipeline register with stall,    |
// | flush and hazard-bubble handling plus debug event counters        |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module id_ex_stage_reg
  import core_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  hazard,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_pc,
  input  logic [DATA_W-1:0]     id_val_rn,
  input  logic [DATA_W-1:0]     id_val_rm,
  input  logic                  id_imm,
  input  logic [11:0]           id_shift_operand,
  input  logic [23:0]           id_signed_imm_24,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic [3:0]            id_exe_cmd,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_wb_en,
  input  logic                  id_b,
  input  logic                  id_s,
  input  logic                  id_carry,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_pc,
  output logic [DATA_W-1:0]     ex_val_rn,
  output logic [DATA_W-1:0]     ex_val_rm,
  output logic                  ex_imm,
  output logic [11:0]           ex_shift_operand,
  output logic [23:0]           ex_signed_imm_24,
  output logic [REG_ADDR_W-1:0] ex_dest,
  output logic [REG_ADDR_W-1:0] ex_src1,
  output logic [REG_ADDR_W-1:0] ex_src2,
  output logic [3:0]            ex_exe_cmd,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_wb_en,
  output logic                  ex_b,
  output logic                  ex_s,
  output logic                  ex_carry,
  output logic [CNT_W-1:0]      bubble_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0]     pc;
    logic [DATA_W-1:0]     val_rn;
    logic [DATA_W-1:0]     val_rm;
    logic                  imm;
    logic [11:0]           shift_operand;
    logic [23:0]           signed_imm_24;
    logic [REG_ADDR_W-1:0] dest;
    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
    logic                  carry;
  } data_bundle_t;

  ctrl_bundle_t ctrl_in;
  data_bundle_t data_in;
  ctrl_bundle_t ctrl_d, ctrl_q;
  data_bundle_t data_d, data_q;
  logic         bubble_inc;

  always_comb begin
    ctrl_in = '{
      exe_cmd:   id_exe_cmd,
      mem_read:  id_mem_read,
      mem_write: id_mem_write,
      wb_en:     id_wb_en,
      b:         id_b,
      s:         id_s,
      valid:     id_valid
    };
    data_in = '{
      pc:            id_pc,
      val_rn:        id_val_rn,
      val_rm:        id_val_rm,
      imm:           id_imm,
      shift_operand: id_shift_operand,
      signed_imm_24: id_signed_imm_24,
      dest:          id_dest,
      src1:          id_src1,
      src2:          id_src2,
      carry:         id_carry
    };
  end

  // Bubbles still capture the data path so forwarding addresses stay observable.
  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (flush) begin
      ctrl_d = BUBBLE_CTRL;
      data_d = data_in;
    end else if (freeze) begin
      ctrl_d = ctrl_q;
      data_d = data_q;
    end else if (hazard) begin
      ctrl_d = BUBBLE_CTRL;
      data_d = data_in;
    end else begin
      ctrl_d = gate_ctrl(ctrl_in);
      data_d = data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= BUBBLE_CTRL;
      data_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  // Only a hazard that actually displaced a real instruction counts as a bubble.
  assign bubble_inc = hazard && id_valid && !flush;

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bubble_inc),
    .hold  (freeze),
    .count (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush),
    .hold  (1'b0),
    .count (flush_cnt)
  );

  assign ex_valid         = ctrl_q.valid;
  assign ex_exe_cmd       = ctrl_q.exe_cmd;
  assign ex_mem_read      = ctrl_q.mem_read;
  assign ex_mem_write     = ctrl_q.mem_write;
  assign ex_wb_en         = ctrl_q.wb_en;
  assign ex_b             = ctrl_q.b;
  assign ex_s             = ctrl_q.s;
  assign ex_pc            = data_q.pc;
  assign ex_val_rn        = data_q.val_rn;
  assign ex_val_rm        = data_q.val_rm;
  assign ex_imm           = data_q.imm;
  assign ex_shift_operand = data_q.shift_operand;
  assign ex_signed_imm_24 = data_q.signed_imm_24;
  assign ex_dest          = data_q.dest;
  assign ex_src1          = data_q.src1;
  assign ex_src2          = data_q.src2;
  assign ex_carry         = data_q.carry;

endmodule
`default_nettype wire
